// File: rtl/registrador_universal.sv
// registrador_universal
// Parametrised universal register: parallel load, clear, hold, and multi-cycle
// logical/arithmetic shifts and rotates by a latched step count, with serial
// fill/out and a Start/Busy/Done handshake. One 1-bit step is taken per clock
// while in SHIFT, so an amount of k costs k cycles plus the one-cycle DONE.
module registrador_universal #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Mode,
  input  logic [CNT_W-1:0] Amount,
  input  logic [WIDTH-1:0] D,
  input  logic             SerialIn,
  output logic [WIDTH-1:0] Q,
  output logic             SerialOut,
  output logic             Busy,
  output logic             Done
);

  // Operation codes.
  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_SHR   = 3'b011;
  localparam logic [2:0] MODE_SAR   = 3'b100;
  localparam logic [2:0] MODE_ROL   = 3'b101;
  localparam logic [2:0] MODE_ROR   = 3'b110;
  localparam logic [2:0] MODE_CLEAR = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             so_q, so_d;
  logic [2:0]       mode_q, mode_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Candidate results of a single 1-bit step for every shift flavour.
  logic [WIDTH-1:0] shl_v;
  logic [WIDTH-1:0] shr_v;
  logic [WIDTH-1:0] sar_v;
  logic [WIDTH-1:0] rol_v;
  logic [WIDTH-1:0] ror_v;

  // Selected step result for the latched mode.
  logic [WIDTH-1:0] step_v;
  logic             step_so;

  // Decoded request in IDLE.
  logic             start_is_shift;
  logic             amount_zero;
  logic             last_step;

  // Per-bit neighbour wiring for each step flavour; bit 0 and the MSB take
  // the fill/wrap bits, every other bit just looks one position over.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_step
      if (gi == 0) begin : g_lsb
        assign shl_v[gi] = SerialIn;
        assign rol_v[gi] = q_q[WIDTH-1];
      end else begin : g_upper
        assign shl_v[gi] = q_q[gi-1];
        assign rol_v[gi] = q_q[gi-1];
      end

      if (gi == WIDTH-1) begin : g_msb
        assign shr_v[gi] = SerialIn;
        assign sar_v[gi] = q_q[WIDTH-1];
        assign ror_v[gi] = q_q[0];
      end else begin : g_lower
        assign shr_v[gi] = q_q[gi+1];
        assign sar_v[gi] = q_q[gi+1];
        assign ror_v[gi] = q_q[gi+1];
      end
    end
  endgenerate

  // Pick the step result and the bit that falls out, based on the latched mode.
  always_comb begin
    step_v  = q_q;
    step_so = so_q;
    case (mode_q)
      MODE_SHL: begin
        step_v  = shl_v;
        step_so = q_q[WIDTH-1];
      end
      MODE_SHR: begin
        step_v  = shr_v;
        step_so = q_q[0];
      end
      MODE_SAR: begin
        step_v  = sar_v;
        step_so = q_q[0];
      end
      MODE_ROL: begin
        step_v  = rol_v;
        step_so = q_q[WIDTH-1];
      end
      MODE_ROR: begin
        step_v  = ror_v;
        step_so = q_q[0];
      end
      default: begin
        step_v  = q_q;
        step_so = so_q;
      end
    endcase
  end

  // Classify the incoming request; HOLD, LOAD and CLEAR never enter SHIFT.
  always_comb begin
    start_is_shift = 1'b0;
    case (Mode)
      MODE_SHL, MODE_SHR, MODE_SAR, MODE_ROL, MODE_ROR: start_is_shift = 1'b1;
      default:                                         start_is_shift = 1'b0;
    endcase
  end

  assign amount_zero = (Amount == '0);
  assign last_step   = (rem_q == CNT_W'(1));

  // Next-state and datapath control. Busy/Done are computed for the next
  // state so that they come straight out of flops.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    so_d    = so_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          mode_d = Mode;
          if (Mode == MODE_LOAD) begin
            q_d = D;
          end else if (Mode == MODE_CLEAR) begin
            q_d = '0;
          end

          if (start_is_shift && !amount_zero) begin
            rem_d   = Amount;
            state_d = ST_SHIFT;
            busy_d  = 1'b1;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end

      ST_SHIFT: begin
        // Mode and Amount are ignored here; only the latched copies matter.
        q_d   = step_v;
        so_d  = step_so;
        rem_d = rem_q - CNT_W'(1);
        if (last_step) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          busy_d  = 1'b1;
        end
      end

      ST_DONE: begin
        // Start is not looked at here; a request must be presented in IDLE.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wins over everything, including a
  // shift in progress, and discards any remaining steps.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      so_q    <= 1'b0;
      mode_q  <= MODE_HOLD;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      so_q    <= so_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Q         = q_q;
  assign SerialOut = so_q;
  assign Busy      = busy_q;
  assign Done      = done_q;

endmodule

// File: tb/tb_registrador_universal.sv
// Self-checking bench for registrador_universal (WIDTH=16, CNT_W=5).
// Directed scenarios plus randomized operations checked cycle by cycle against
// an arithmetic reference model of the register.
module tb_registrador_universal;

  localparam logic [2:0] M_HOLD  = 3'd0;
  localparam logic [2:0] M_LOAD  = 3'd1;
  localparam logic [2:0] M_SHL   = 3'd2;
  localparam logic [2:0] M_SHR   = 3'd3;
  localparam logic [2:0] M_SAR   = 3'd4;
  localparam logic [2:0] M_ROL   = 3'd5;
  localparam logic [2:0] M_ROR   = 3'd6;
  localparam logic [2:0] M_CLEAR = 3'd7;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [2:0]  Mode = 3'd0;
  logic [4:0]  Amount = 5'd0;
  logic [15:0] D = 16'h0000;
  logic        SerialIn = 1'b0;
  logic [15:0] Q;
  logic        SerialOut;
  logic        Busy;
  logic        Done;

  int errors = 0;
  int checks = 0;

  // Samples taken #1 after each edge of one operation (index 0 = accepting edge).
  logic [15:0] obs_q    [0:40];
  logic        obs_so   [0:40];
  logic        obs_busy [0:40];
  logic        obs_done [0:40];
  logic        si_used  [0:40];
  int          n_rec;

  // Reference model state.
  logic [15:0] m_q;
  logic        m_so;

  registrador_universal #(.WIDTH(16), .CNT_W(5)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Mode(Mode), .Amount(Amount),
    .D(D), .SerialIn(SerialIn), .Q(Q), .SerialOut(SerialOut),
    .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic bit is_shift(input logic [2:0] mode);
    return (mode == M_SHL) || (mode == M_SHR) || (mode == M_SAR) ||
           (mode == M_ROL) || (mode == M_ROR);
  endfunction

  // One shift step on the model, written with integer arithmetic.
  task automatic model_step(input logic [2:0] mode, input logic si);
    int unsigned v;
    int unsigned s;
    v = int'(m_q);
    s = si ? 1 : 0;
    case (mode)
      M_SHL: begin m_so = v[15]; v = ((v << 1) | s) & 32'hFFFF; end
      M_SHR: begin m_so = v[0];  v = (v >> 1) | (s << 15); end
      M_SAR: begin m_so = v[0];  v = (v >> 1) | (v & 32'h8000); end
      M_ROL: begin m_so = v[15]; v = ((v << 1) | (v >> 15)) & 32'hFFFF; end
      M_ROR: begin m_so = v[0];  v = (v >> 1) | ((v & 1) << 15); end
      default: ;
    endcase
    m_q = v[15:0];
  endtask

  task automatic model_single(input logic [2:0] mode, input logic [15:0] d);
    if (mode == M_LOAD) m_q = d;
    else if (mode == M_CLEAR) m_q = 16'h0000;
  endtask

  // Drives one operation and records outputs; makes no comparisons.
  task automatic do_op(input logic [2:0] mode, input int amt, input logic [15:0] d,
                       input int si_sel, input int pulse_at, input int rst_at);
    int nsamp;
    logic si;
    nsamp = (is_shift(mode) && amt > 0) ? amt + 2 : 2;
    @(negedge Clk);
    Start = 1'b1; Mode = mode; Amount = 5'(amt); D = d;
    @(posedge Clk); #1;
    obs_q[0] = Q; obs_so[0] = SerialOut; obs_busy[0] = Busy; obs_done[0] = Done;
    n_rec = 1;
    Start = 1'b0; Mode = 3'($urandom); Amount = 5'($urandom); D = 16'($urandom);
    for (int i = 1; i < nsamp; i++) begin
      @(negedge Clk);
      si = (si_sel == 2) ? 1'($urandom_range(0, 1)) : (si_sel == 1);
      si_used[i] = si;
      SerialIn = si;
      if (i == pulse_at) begin Start = 1'b1; Mode = M_CLEAR; end
      if (i == rst_at) Reset = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      obs_q[i] = Q; obs_so[i] = SerialOut; obs_busy[i] = Busy; obs_done[i] = Done;
      n_rec = i + 1;
      if (i == rst_at) begin Reset = 1'b0; break; end
    end
    $display("op mode=%0d amt=%0d d=%h samples=%0d q=%h so=%b",
             mode, amt, d, n_rec, obs_q[n_rec-1], obs_so[n_rec-1]);
  endtask

  task automatic test_reset();
    @(negedge Clk);
    Reset = 1'b1; Start = 1'b1; Mode = M_LOAD; D = 16'hFFFF;
    repeat (2) @(posedge Clk);
    #1;
    checks++; if (Q !== 16'h0000) begin errors++; $display("FAIL reset_q got=%h exp=0000", Q); end
    checks++; if (SerialOut !== 1'b0) begin errors++; $display("FAIL reset_so got=%b exp=0", SerialOut); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", Done); end
    Reset = 1'b0; Start = 1'b0;
    m_q = 16'h0000; m_so = 1'b0;
    $display("reset applied q=%h so=%b busy=%b done=%b", Q, SerialOut, Busy, Done);
  endtask

  task automatic test_load();
    do_op(M_LOAD, 0, 16'hA5C3, 0, -1, -1);
    model_single(M_LOAD, 16'hA5C3);
    checks++; if (obs_q[0] !== 16'hA5C3) begin errors++; $display("FAIL load_q got=%h exp=a5c3", obs_q[0]); end
    checks++; if (obs_done[0] !== 1'b1) begin errors++; $display("FAIL load_done0 got=%b exp=1", obs_done[0]); end
    checks++; if (obs_done[1] !== 1'b0) begin errors++; $display("FAIL load_done1 got=%b exp=0", obs_done[1]); end
    checks++; if (obs_busy[0] !== 1'b0 || obs_busy[1] !== 1'b0) begin
      errors++; $display("FAIL load_busy got=%b%b exp=00", obs_busy[0], obs_busy[1]); end
    checks++; if (obs_so[1] !== 1'b0) begin errors++; $display("FAIL load_so got=%b exp=0", obs_so[1]); end
  endtask

  task automatic test_shl();
    logic [15:0] exp_seq [1:3];
    exp_seq[1] = 16'h0003; exp_seq[2] = 16'h0007; exp_seq[3] = 16'h000F;
    do_op(M_LOAD, 0, 16'h8001, 0, -1, -1);
    model_single(M_LOAD, 16'h8001);
    do_op(M_SHL, 3, 16'h0000, 1, -1, -1);
    for (int i = 1; i <= 3; i++) begin
      model_step(M_SHL, si_used[i]);
      checks++; if (obs_q[i] !== exp_seq[i] || obs_q[i] !== m_q) begin
        errors++; $display("FAIL shl_q step%0d got=%h exp=%h", i, obs_q[i], exp_seq[i]); end
      checks++; if (obs_busy[i-1] !== 1'b1) begin
        errors++; $display("FAIL shl_busy s%0d got=%b exp=1", i-1, obs_busy[i-1]); end
    end
    checks++; if (obs_so[3] !== 1'b0) begin errors++; $display("FAIL shl_so got=%b exp=0", obs_so[3]); end
    checks++; if (obs_done[3] !== 1'b1 || obs_busy[3] !== 1'b0) begin
      errors++; $display("FAIL shl_done3 got done=%b busy=%b exp done=1 busy=0", obs_done[3], obs_busy[3]); end
    checks++; if (obs_done[4] !== 1'b0 || obs_done[2] !== 1'b0) begin
      errors++; $display("FAIL shl_done_pulse got d2=%b d4=%b exp 0 0", obs_done[2], obs_done[4]); end
  endtask

  task automatic test_sar_ror();
    do_op(M_LOAD, 0, 16'h8F00, 0, -1, -1);
    model_single(M_LOAD, 16'h8F00);
    do_op(M_SAR, 4, 16'h0000, 2, -1, -1);
    for (int i = 1; i <= 4; i++) model_step(M_SAR, si_used[i]);
    checks++; if (obs_q[4] !== 16'hF8F0 || obs_q[4] !== m_q) begin
      errors++; $display("FAIL sar_q got=%h exp=f8f0", obs_q[4]); end
    checks++; if (obs_so[4] !== 1'b0) begin errors++; $display("FAIL sar_so got=%b exp=0", obs_so[4]); end
    do_op(M_LOAD, 0, 16'h1234, 0, -1, -1);
    model_single(M_LOAD, 16'h1234);
    do_op(M_ROR, 4, 16'h0000, 2, -1, -1);
    for (int i = 1; i <= 4; i++) model_step(M_ROR, si_used[i]);
    checks++; if (obs_q[4] !== 16'h4123 || obs_q[4] !== m_q) begin
      errors++; $display("FAIL ror_q got=%h exp=4123", obs_q[4]); end
    checks++; if (obs_so[4] !== 1'b0) begin errors++; $display("FAIL ror_so got=%b exp=0", obs_so[4]); end
  endtask

  task automatic test_amount0_ignore();
    do_op(M_LOAD, 0, 16'h00FF, 0, -1, -1);
    model_single(M_LOAD, 16'h00FF);
    do_op(M_SHR, 0, 16'h0000, 1, -1, -1);
    checks++; if (obs_q[0] !== 16'h00FF || obs_done[0] !== 1'b1 || obs_busy[0] !== 1'b0) begin
      errors++; $display("FAIL amt0 got q=%h done=%b busy=%b exp q=00ff done=1 busy=0",
                         obs_q[0], obs_done[0], obs_busy[0]); end
    // A CLEAR request pulsed in the middle of a 5-step shift must be ignored.
    do_op(M_SHL, 5, 16'h0000, 2, 2, -1);
    for (int i = 1; i <= 5; i++) begin
      model_step(M_SHL, si_used[i]);
      checks++; if (obs_q[i] !== m_q) begin
        errors++; $display("FAIL ignore_q step%0d got=%h exp=%h", i, obs_q[i], m_q); end
    end
    checks++; if (obs_done[5] !== 1'b1 || obs_busy[4] !== 1'b1 || obs_busy[5] !== 1'b0) begin
      errors++; $display("FAIL ignore_hs got done5=%b busy4=%b busy5=%b exp 1 1 0",
                         obs_done[5], obs_busy[4], obs_busy[5]); end
  endtask

  task automatic test_reset_mid();
    do_op(M_LOAD, 0, 16'hFFFF, 0, -1, -1);
    model_single(M_LOAD, 16'hFFFF);
    do_op(M_SHL, 5, 16'h0000, 1, -1, 3);
    model_step(M_SHL, si_used[1]);
    model_step(M_SHL, si_used[2]);
    checks++; if (obs_q[2] !== m_q) begin errors++; $display("FAIL rstmid_step2 got=%h exp=%h", obs_q[2], m_q); end
    m_q = 16'h0000; m_so = 1'b0;
    checks++; if (n_rec !== 4 || obs_q[3] !== 16'h0000 || obs_so[3] !== 1'b0) begin
      errors++; $display("FAIL rstmid_q got=%h so=%b exp q=0000 so=0", obs_q[3], obs_so[3]); end
    checks++; if (obs_busy[3] !== 1'b0 || obs_done[3] !== 1'b0) begin
      errors++; $display("FAIL rstmid_hs got busy=%b done=%b exp 0 0", obs_busy[3], obs_done[3]); end
    do_op(M_LOAD, 0, 16'h1234, 0, -1, -1);
    model_single(M_LOAD, 16'h1234);
    checks++; if (obs_q[0] !== 16'h1234 || obs_done[0] !== 1'b1) begin
      errors++; $display("FAIL rstmid_load got q=%h done=%b exp q=1234 done=1", obs_q[0], obs_done[0]); end
  endtask

  task automatic test_rol16();
    int nbusy;
    do_op(M_LOAD, 0, 16'hBEEF, 0, -1, -1);
    model_single(M_LOAD, 16'hBEEF);
    do_op(M_ROL, 16, 16'h0000, 2, -1, -1);
    for (int i = 1; i <= 16; i++) model_step(M_ROL, si_used[i]);
    nbusy = 0;
    for (int i = 0; i < n_rec; i++) if (obs_busy[i] === 1'b1) nbusy++;
    checks++; if (nbusy !== 16) begin errors++; $display("FAIL rol16_busy got=%0d exp=16", nbusy); end
    checks++; if (obs_q[16] !== 16'hBEEF || obs_q[16] !== m_q) begin
      errors++; $display("FAIL rol16_q got=%h exp=beef", obs_q[16]); end
    checks++; if (obs_so[16] !== 1'b1) begin errors++; $display("FAIL rol16_so got=%b exp=1", obs_so[16]); end
    checks++; if (obs_done[16] !== 1'b1) begin errors++; $display("FAIL rol16_done got=%b exp=1", obs_done[16]); end
  endtask

  task automatic test_random();
    logic [2:0]  mode;
    logic [15:0] d;
    int          amt;
    for (int t = 0; t < 40; t++) begin
      mode = 3'($urandom_range(0, 7));
      amt  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 6));
      d    = 16'($urandom);
      do_op(mode, amt, d, 2, -1, -1);
      if (!(is_shift(mode) && amt > 0)) begin
        model_single(mode, d);
        checks++; if (obs_q[0] !== m_q || obs_so[0] !== m_so) begin
          errors++; $display("FAIL rand_single op%0d got q=%h so=%b exp q=%h so=%b",
                             t, obs_q[0], obs_so[0], m_q, m_so); end
        checks++; if (obs_done[0] !== 1'b1 || obs_busy[0] !== 1'b0 || obs_done[1] !== 1'b0) begin
          errors++; $display("FAIL rand_single_hs op%0d got d0=%b b0=%b d1=%b exp 1 0 0",
                             t, obs_done[0], obs_busy[0], obs_done[1]); end
      end else begin
        checks++; if (obs_q[0] !== m_q || obs_busy[0] !== 1'b1 || obs_done[0] !== 1'b0) begin
          errors++; $display("FAIL rand_accept op%0d got q=%h busy=%b done=%b exp q=%h busy=1 done=0",
                             t, obs_q[0], obs_busy[0], obs_done[0], m_q); end
        for (int i = 1; i <= amt; i++) begin
          model_step(mode, si_used[i]);
          checks++; if (obs_q[i] !== m_q || obs_so[i] !== m_so) begin
            errors++; $display("FAIL rand_step op%0d s%0d got q=%h so=%b exp q=%h so=%b",
                               t, i, obs_q[i], obs_so[i], m_q, m_so); end
          checks++; if (obs_busy[i] !== (i < amt) || obs_done[i] !== (i == amt)) begin
            errors++; $display("FAIL rand_hs op%0d s%0d got busy=%b done=%b exp busy=%b done=%b",
                               t, i, obs_busy[i], obs_done[i], (i < amt), (i == amt)); end
        end
        checks++; if (obs_busy[amt+1] !== 1'b0 || obs_done[amt+1] !== 1'b0 || obs_q[amt+1] !== m_q) begin
          errors++; $display("FAIL rand_tail op%0d got busy=%b done=%b q=%h exp 0 0 %h",
                             t, obs_busy[amt+1], obs_done[amt+1], obs_q[amt+1], m_q); end
      end
    end
  endtask

  initial begin
    m_q = 16'h0000;
    m_so = 1'b0;
    n_rec = 0;
    test_reset();
    test_load();
    test_shl();
    test_sar_ror();
    test_amount0_ignore();
    test_reset_mid();
    test_rol16();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
